// File: rtl/mmio_controller.sv
// -----------------------------------------------------------------------------
// mmio_controller
//
// Memory-mapped I/O window sitting between a core and its data memory.
// Accesses inside the window are served by local registers; accesses outside
// pass straight through to data memory.
//
// Window layout (word offsets from BASE_ADDR):
//   0 .. N_IN-1        debounced input channel i           (read only)
//   N_IN               STATUS, one bit per input channel   (write 1 to clear)
//   N_IN+1             ENABLE, one bit per input channel   (read/write)
//   N_IN+2 .. +N_OUT-1 output register j                   (read/write)
//
// Ports:
//   CLK       clock, all state updates on the rising edge
//   RST       synchronous active-high reset
//   A         word address from the core
//   RD        read data from data memory
//   WD        write data from the core
//   WE_IN     core write enable
//   SW_IN     raw asynchronous inputs, channel i = [i*IN_W +: IN_W]
//   WE_OUT    write enable forwarded to data memory (blocked inside window)
//   RD_OUT    read data to the core (mapped register inside window)
//   OUT_DATA  output registers, register j = [j*OUT_W +: OUT_W]
//   IRQ       registered OR of (STATUS & ENABLE)
// -----------------------------------------------------------------------------
module mmio_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd81928,
    parameter int          N_IN      = 2,
    parameter int          IN_W      = 5,
    parameter int          N_OUT     = 2,
    parameter int          OUT_W     = 8,
    parameter int          DEBOUNCE  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              A,
    input  logic [31:0]              RD,
    input  logic [31:0]              WD,
    input  logic                     WE_IN,
    input  logic [N_IN*IN_W-1:0]     SW_IN,
    output logic                     WE_OUT,
    output logic [31:0]              RD_OUT,
    output logic [N_OUT*OUT_W-1:0]   OUT_DATA,
    output logic                     IRQ
);

    localparam int          WIN   = N_IN + 2 + N_OUT;
    localparam int          CNT_W = $clog2(DEBOUNCE + 1);
    // The window bounds are held in 33 bits so a window ending at the top of
    // the address space does not wrap around to low addresses.
    localparam logic [32:0] LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI    = LO + 33'(WIN);

    logic [N_IN-1:0][IN_W-1:0]   sync1;
    logic [N_IN-1:0][IN_W-1:0]   sync2;
    logic [N_IN-1:0][IN_W-1:0]   deb;
    logic [N_IN-1:0][CNT_W-1:0]  cnt;
    logic [N_IN-1:0][CNT_W-1:0]  cnt_nxt;
    logic [N_IN-1:0]             done;
    logic [N_IN-1:0]             status;
    logic [N_IN-1:0]             enable;
    logic [N_OUT-1:0][OUT_W-1:0] out_reg;

    logic        in_window;
    logic [31:0] offset;
    logic        wr_status;
    logic        wr_enable;
    logic [N_OUT-1:0] wr_out;
    logic [31:0] mapped;

    // Only the low bits of WD feed registers; the rest is deliberately dropped.
    logic unused_wd;
    assign unused_wd = ^WD;

    assign in_window = ({1'b0, A} >= LO) && ({1'b0, A} < HI);
    assign offset    = A - BASE_ADDR;

    assign wr_status = WE_IN && in_window && (offset == 32'(N_IN));
    assign wr_enable = WE_IN && in_window && (offset == 32'(N_IN + 1));

    assign WE_OUT   = in_window ? 1'b0 : WE_IN;
    assign RD_OUT   = in_window ? mapped : RD;
    assign OUT_DATA = out_reg;

    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_out = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (WE_IN && in_window && (offset == 32'(N_IN + 2 + j))) begin
                wr_out[j] = 1'b1;
            end
        end
    end

    // Debounce: count consecutive cycles the synchronized value disagrees with
    // the accepted value; any agreement restarts the count.
    always_comb begin
        done    = '0;
        cnt_nxt = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                    done[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mapped = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (offset == 32'(i)) begin
                mapped = 32'(deb[i]);
            end
        end
        if (offset == 32'(N_IN)) begin
            mapped = 32'(status);
        end
        if (offset == 32'(N_IN + 1)) begin
            mapped = 32'(enable);
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (offset == 32'(N_IN + 2 + j)) begin
                mapped = 32'(out_reg[j]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    // NOTE: the reset branch clears every register, including the debounce
    // counters and output registers, and takes priority over writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            cnt     <= '0;
            status  <= '0;
            enable  <= '0;
            out_reg <= '0;
            IRQ     <= 1'b0;
        end else begin
            sync1 <= SW_IN;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            for (int i = 0; i < N_IN; i++) begin
                if (done[i]) begin
                    deb[i] <= sync2[i];
                end
            end
            // A completion on the same edge as a clear keeps the bit set.
            status <= (status & ~(wr_status ? WD[N_IN-1:0] : '0)) | done;
            if (wr_enable) begin
                enable <= WD[N_IN-1:0];
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_out[j]) begin
                    out_reg[j] <= WD[OUT_W-1:0];
                end
            end
            IRQ <= |(status & enable);
        end
    end

endmodule

// File: tb/tb_mmio_controller.sv
// -----------------------------------------------------------------------------
// tb_mmio_controller
//
// Two instances: u0 with default parameters, u1 with four 1-bit inputs, three
// 16-bit outputs, DEBOUNCE=1 and a window ending at the top of the address
// space. Each check compares a selected DUT output against a hand-computed
// expectation once the combinational paths have settled.
// -----------------------------------------------------------------------------
module tb_mmio_controller;

    localparam logic [31:0] B0 = 32'd81928;
    localparam logic [31:0] B1 = 32'hFFFF_FFF7;

    typedef enum int {S_RD0, S_WE0, S_OUT0, S_IRQ0, S_RD1, S_WE1, S_OUT1, S_IRQ1} sel_t;

    logic        clk;
    logic        rst;
    logic [31:0] a0, rd0, wd0, a1, rd1, wd1;
    logic        we0, we1;
    logic [9:0]  sw0;
    logic [3:0]  sw1;
    logic        we_out0, we_out1, irq0, irq1;
    logic [31:0] rd_out0, rd_out1;
    logic [15:0] out0;
    logic [47:0] out1;

    int   n_vec = 0;
    int   n_bad = 0;

    mmio_controller u0 (
        .CLK(clk), .RST(rst), .A(a0), .RD(rd0), .WD(wd0), .WE_IN(we0),
        .SW_IN(sw0), .WE_OUT(we_out0), .RD_OUT(rd_out0), .OUT_DATA(out0), .IRQ(irq0)
    );

    mmio_controller #(
        .BASE_ADDR(B1), .N_IN(4), .IN_W(1), .N_OUT(3), .OUT_W(16), .DEBOUNCE(1)
    ) u1 (
        .CLK(clk), .RST(rst), .A(a1), .RD(rd1), .WD(wd1), .WE_IN(we1),
        .SW_IN(sw1), .WE_OUT(we_out1), .RD_OUT(rd_out1), .OUT_DATA(out1), .IRQ(irq1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] actual(input sel_t s);
        case (s)
            S_RD0:   return 64'(rd_out0);
            S_WE0:   return 64'(we_out0);
            S_OUT0:  return 64'(out0);
            S_IRQ0:  return 64'(irq0);
            S_RD1:   return 64'(rd_out1);
            S_WE1:   return 64'(we_out1);
            S_OUT1:  return 64'(out1);
            default: return 64'(irq1);
        endcase
    endfunction

    task automatic check(input string name, input sel_t sel, input logic [63:0] exp);
        logic [63:0] act;
        #1;
        act = actual(sel);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a0 = '0; rd0 = 32'hDEAD_BEEF; wd0 = '0; we0 = 1'b0; sw0 = '0;
        a1 = '0; rd1 = 32'hCAFE_F00D; wd1 = '0; we1 = 1'b0; sw1 = '0;
        step();

        // Writes during reset are overridden; combinational paths stay live.
        a0 = B0 + 4; wd0 = 32'hFF; we0 = 1'b1;
        a1 = B1 + 6; wd1 = 32'h1234; we1 = 1'b1;
        check("rst_we_out_in_window", S_WE0, 64'd0);
        step();
        we0 = 1'b0; we1 = 1'b0;
        check("rst_out0", S_OUT0, 64'd0);
        check("rst_rd_mapped0", S_RD0, 64'd0);
        check("rst_irq0", S_IRQ0, 64'd0);
        check("rst_out1", S_OUT1, 64'd0);
        step();
        a0 = 32'd81900; we0 = 1'b1;
        check("rst_rd_pass0", S_RD0, 64'hDEAD_BEEF);
        check("rst_we_pass0", S_WE0, 64'd1);
        step();
        rst = 1'b0; we0 = 1'b0;

        // Output register write, upper WD bits dropped.
        a0 = B0 + 4; wd0 = 32'h1A5; we0 = 1'b1;
        check("wr_out0_we_blocked", S_WE0, 64'd0);
        step();
        we0 = 1'b0;
        check("out0_after_write", S_OUT0, 64'h00A5);
        check("rd_out0_reg", S_RD0, 64'h0000_00A5);
        a0 = B0 + 5; wd0 = 32'h3C; we0 = 1'b1;
        step();
        we0 = 1'b0;
        check("out1_after_write", S_OUT0, 64'h3CA5);
        check("rd_out1_reg", S_RD0, 64'h3C);

        // Out-of-window pass-through, including both window edges.
        a0 = 32'd81900; wd0 = 32'h55; we0 = 1'b1;
        check("pass_we", S_WE0, 64'd1);
        check("pass_rd", S_RD0, 64'hDEAD_BEEF);
        step();
        a0 = B0 + 6;
        check("win_top_we", S_WE0, 64'd1);
        check("win_top_rd", S_RD0, 64'hDEAD_BEEF);
        step();
        a0 = B0 - 1;
        check("win_bottom_we", S_WE0, 64'd1);
        step();
        we0 = 1'b0;
        check("pass_no_state_change", S_OUT0, 64'h3CA5);

        // Writes to an input offset are ignored.
        a0 = B0; wd0 = 32'h1F; we0 = 1'b1;
        check("wr_input_we_blocked", S_WE0, 64'd0);
        step();
        we0 = 1'b0;
        check("wr_input_ignored", S_RD0, 64'd0);

        // Debounce latency: stable from edge t, visible after edge t+5.
        sw0 = {5'h00, 5'h13};
        step();                   // edge t
        repeat (4) step();        // edge t+4
        check("deb_not_yet", S_RD0, 64'd0);
        step();                   // edge t+5
        check("deb_ch0_13", S_RD0, 64'h13);
        step();
        a0 = B0 + 2;
        check("status_after_deb", S_RD0, 64'd1);
        check("irq_disabled", S_IRQ0, 64'd0);

        // Three-cycle glitch on ch1 is rejected.
        sw0 = {5'h0A, 5'h13};
        step(); step(); step();
        sw0 = {5'h00, 5'h13};
        repeat (6) step();
        a0 = B0 + 1;
        check("glitch_ch1_ignored", S_RD0, 64'd0);
        step();
        a0 = B0 + 2;
        check("glitch_status_unchanged", S_RD0, 64'd1);

        // STATUS clear, ENABLE, IRQ.
        wd0 = 32'd1; we0 = 1'b1;
        step();
        we0 = 1'b0;
        check("status_w1c", S_RD0, 64'd0);
        a0 = B0 + 3; wd0 = 32'hFFFF_FFFD; we0 = 1'b1;
        step();
        we0 = 1'b0;
        check("enable_rd", S_RD0, 64'd1);
        check("irq_idle", S_IRQ0, 64'd0);
        sw0 = {5'h00, 5'h07};
        step();                   // edge t
        repeat (4) step();        // edge t+4
        step();                   // edge t+5: STATUS sets
        a0 = B0 + 2;
        check("status_set_irq", S_RD0, 64'd1);
        check("irq_lags_status", S_IRQ0, 64'd0);
        step();                   // edge t+6
        check("irq_asserted", S_IRQ0, 64'd1);
        wd0 = 32'd1; we0 = 1'b1;
        step();
        we0 = 1'b0;
        check("status_cleared", S_RD0, 64'd0);
        check("irq_still_high", S_IRQ0, 64'd1);
        step();
        check("irq_cleared", S_IRQ0, 64'd0);

        // Clear coincident with a new completion: the set wins.
        sw0 = {5'h00, 5'h00};
        step();                   // edge t
        repeat (4) step();        // edge t+4
        wd0 = 32'd1; we0 = 1'b1;
        step();                   // edge t+5
        we0 = 1'b0;
        check("set_beats_clear", S_RD0, 64'd1);
        step();
        check("irq_after_coincident", S_IRQ0, 64'd1);

        // Reset mid-debounce with IRQ pending.
        sw0 = {5'h1F, 5'h00};
        step(); step(); step();
        rst = 1'b1;
        step();                   // reset edge R
        rst = 1'b0;
        check("rst_irq", S_IRQ0, 64'd0);
        check("rst_out", S_OUT0, 64'd0);
        check("rst_status", S_RD0, 64'd0);
        step();                   // R+1
        a0 = B0 + 3;
        check("rst_enable", S_RD0, 64'd0);
        step();                   // R+2
        a0 = B0 + 1;
        repeat (3) step();        // R+5
        check("restart_not_yet", S_RD0, 64'd0);
        step();                   // R+6
        check("restart_accept", S_RD0, 64'h1F);
        step();
        a0 = B0 + 2;
        check("restart_status", S_RD0, 64'd2);
        check("restart_irq_off", S_IRQ0, 64'd0);

        // Alternate parameter set: window at top of address space.
        a1 = B1 + 8; wd1 = 32'h0001_BEEF; we1 = 1'b1;
        check("p2_top_in_window", S_WE1, 64'd0);
        step();
        we1 = 1'b0;
        check("p2_out2", S_OUT1, 64'hBEEF_0000_0000);
        check("p2_rd_out2", S_RD1, 64'h0000_BEEF);
        a1 = 32'h0; we1 = 1'b1;
        check("p2_no_wrap_we", S_WE1, 64'd1);
        check("p2_no_wrap_rd", S_RD1, 64'hCAFE_F00D);
        step();
        a1 = B1 - 1;
        check("p2_below_we", S_WE1, 64'd1);
        check("p2_below_rd", S_RD1, 64'hCAFE_F00D);
        step();
        we1 = 1'b0;
        check("p2_pass_no_change", S_OUT1, 64'hBEEF_0000_0000);
        a1 = B1 + 6; wd1 = 32'h1234; we1 = 1'b1;
        step();
        we1 = 1'b0;
        check("p2_out0", S_OUT1, 64'hBEEF_0000_1234);

        sw1 = 4'b0100;
        step();                   // edge t
        step();                   // edge t+1
        a1 = B1 + 2;
        check("p2_deb_not_yet", S_RD1, 64'd0);
        step();                   // edge t+2
        check("p2_deb_accept", S_RD1, 64'd1);
        step();
        a1 = B1 + 4;
        check("p2_status", S_RD1, 64'h4);

        a1 = B1 + 5; wd1 = 32'hFFFF_FFF4; we1 = 1'b1;
        step();
        we1 = 1'b0;
        check("p2_enable", S_RD1, 64'h4);
        check("p2_irq_lag", S_IRQ1, 64'd0);
        step();
        check("p2_irq", S_IRQ1, 64'd1);

        a1 = B1 + 3; wd1 = 32'd1; we1 = 1'b1;
        check("p2_wr_input_blocked", S_WE1, 64'd0);
        step();
        we1 = 1'b0;
        check("p2_wr_input_ignored", S_RD1, 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_controller.md
MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 Parameter BASE_ADDR, default 32'd81928, SHALL set the first word address of the I/O window.
REQ-002 Parameter N_IN, default 2, SHALL set the number of input channels (1..16).
REQ-003 Parameter IN_W, default 5, SHALL set the bits per input channel (1..32).
REQ-004 Parameter N_OUT, default 2, SHALL set the number of output registers (1..16).
REQ-005 Parameter OUT_W, default 8, SHALL set the bits per output register (1..32).
REQ-006 Parameter DEBOUNCE, default 4, SHALL set the stable-cycle count (>=1) needed to accept an input change.
REQ-007 Ports SHALL be, in order:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- A  in  32  word address from core
- RD  in  32  read data from data memory
- WD  in  32  write data from core
- WE_IN  in  1  core write enable
- SW_IN  in  N_IN*IN_W  raw asynchronous inputs; channel i = bits [i*IN_W +: IN_W]
- WE_OUT  out  1  write enable forwarded to data memory
- RD_OUT  out  32  read data returned to core
- OUT_DATA  out  N_OUT*OUT_W  output registers; register j = bits [j*OUT_W +: OUT_W]
- IRQ  out  1  registered interrupt request

Function
REQ-008 Address map, offset = A-BASE_ADDR:
- 0..N_IN-1: debounced input i (RO)
- N_IN: STATUS, N_IN bits (W1C)
- N_IN+1: ENABLE, N_IN bits (RW)
- N_IN+2+j: output register j (RW)
REQ-009 An address is "in window" iff BASE_ADDR <= A < BASE_ADDR+N_IN+2+N_OUT; width-arithmetic SHALL not wrap past 2^32.
REQ-010 WE_OUT SHALL equal WE_IN when A is out of window and 0 when in window (combinational).
REQ-011 RD_OUT SHALL equal RD out of window and the zero-extended mapped register in window (combinational, same cycle).
REQ-012 Writes to input-channel offsets SHALL be ignored.
REQ-013 Each input channel SHALL pass through a 2-flop synchronizer before debounce.
REQ-014 Per channel, a counter SHALL increment each cycle the synchronized value differs from the debounced value and clear whenever they are equal.
REQ-015 When the counter would reach DEBOUNCE, the debounced value SHALL take the synchronized value, the counter SHALL clear and STATUS bit i SHALL set, all on the same edge.
REQ-016 A change on SW_IN stable from edge t SHALL appear in the debounced value and STATUS after edge t+1+DEBOUNCE; a change held less than DEBOUNCE cycles after synchronization SHALL produce no update.
REQ-017 A new, different value arriving mid-count SHALL keep counting only while unequal to the debounced value; the value accepted is the synchronized value on the completing edge.
REQ-018 A write to STATUS SHALL clear each bit whose WD bit is 1; a same-edge set from REQ-015 SHALL win over the clear.
REQ-019 Writes to ENABLE and output registers SHALL take WD[N_IN-1:0] / WD[OUT_W-1:0] on the edge where WE_IN=1 and A matches; upper WD bits are ignored.
REQ-020 IRQ SHALL be registered as |(STATUS & ENABLE), updating one edge after STATUS or ENABLE changes.

Reset
REQ-021 While RST=1 at an edge, synchronizers, debounced values, counters, STATUS, ENABLE, output registers and IRQ SHALL load 0; RST SHALL override any same-edge write or debounce completion.
REQ-022 WE_OUT and RD_OUT SHALL remain combinational during reset (pass-through/mapped rules still apply, mapped values reading 0).

Verification
REQ-023 Defaults; write 0x1A5 to 81932 (output 0) -> OUT_DATA[7:0]=0xA5 next cycle, WE_OUT=0; read 81932 returns 0x000000A5.
REQ-024 Write 0x55 to 81900 with WE_IN=1 -> WE_OUT=1 same cycle, no internal state change; read 81900 returns RD.
REQ-025 SW_IN ch0 0->5'h13 stable from edge t -> read 81928 returns 0x13 after edge t+5, STATUS=01; 3-cycle glitch -> no change.
REQ-026 ENABLE=01 then ch0 change -> IRQ=1 one edge after STATUS sets; write 01 to STATUS -> STATUS=0, IRQ=0 next edge; W1C coincident with new set -> bit stays 1.
REQ-027 RST pulsed mid-debounce and with pending IRQ -> all registers 0, IRQ=0, counting restarts from 0.
REQ-028 Parameter set N_IN=4, IN_W=1, N_OUT=3, OUT_W=16, DEBOUNCE=1 -> map, window edges (BASE+8 in, BASE+9 out) and latency t+2 verified.
